// File: rtl/isa_io_responder_pkg.sv
// Shared definitions for the SM2201 ISA I/O responder: decode defaults,
// FSM state encoding and the value returned on a timed-out read.
package sm2201_isa_pkg;

   localparam logic [9:0]  BASE_ADDR_DEF   = 10'h100;
   localparam int unsigned WINDOW_BITS_DEF = 6;
   localparam int unsigned WINDOW_SIZE     = 1 << WINDOW_BITS_DEF;
   localparam logic [7:0]  TIMEOUT_RD_DATA = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_ACK,
      ST_HOLD
   } isa_state_e;

   // True when addr lies in the window of 2**wbits bytes starting at base.
   function automatic logic addr_hit(input logic [9:0]  addr,
                                     input logic [9:0]  base,
                                     input int unsigned wbits);
      logic [9:0] mask;
      mask = '1;
      mask = mask << wbits;
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/isa_io_responder_if.sv
// ISA I/O bus plus back-end register port of the responder, bundled as one interface.
interface isa_io_responder_if #(
   parameter int unsigned WINDOW_BITS = 6
);
   logic [9:0]             isa_addr;
   logic                   isa_ale;
   logic                   isa_aen;
   logic                   isa_ior;
   logic                   isa_iow;
   logic [7:0]             isa_data_in;
   logic [7:0]             isa_data_out;
   logic                   isa_data_oe;
   logic                   isa_chrdy;
   logic [WINDOW_BITS-1:0] reg_addr;
   logic [7:0]             reg_wr_data;
   logic                   reg_wr;
   logic                   reg_rd;
   logic [7:0]             reg_rd_data;
   logic                   reg_ack;
   logic                   cycle_error;

   modport slave (
      input  isa_addr, isa_ale, isa_aen, isa_ior, isa_iow, isa_data_in,
             reg_rd_data, reg_ack,
      output isa_data_out, isa_data_oe, isa_chrdy, reg_addr, reg_wr_data,
             reg_wr, reg_rd, cycle_error
   );

   modport master (
      output isa_addr, isa_ale, isa_aen, isa_ior, isa_iow, isa_data_in,
             reg_rd_data, reg_ack,
      input  isa_data_out, isa_data_oe, isa_chrdy, reg_addr, reg_wr_data,
             reg_wr, reg_rd, cycle_error
   );
endinterface

// File: rtl/isa_io_responder_strobe_sync.sv
// Two-flop synchronisers for the active-low IOR/IOW strobes plus falling-edge detect.
module isa_strobe_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ior_n,
   input  logic i_iow_n,
   output logic o_rd_act,
   output logic o_wr_act,
   output logic o_rd_edge,
   output logic o_wr_edge
);

   logic [1:0] r_s1;
   logic [1:0] r_s2;
   logic [1:0] r_s3;

   // Reset to the "active" level: a strobe held low across reset must not be
   // seen as a fresh edge, so no request is issued when reset is released.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= {i_iow_n, i_ior_n};
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rd_act  = ~r_s2[0];
   assign o_wr_act  = ~r_s2[1];
   assign o_rd_edge = ~r_s2[0] & r_s3[0];
   assign o_wr_edge = ~r_s2[1] & r_s3[1];

endmodule

// File: rtl/isa_io_responder.sv
// ISA I/O target: decodes the I/O window, stretches the cycle with CHRDY while
// the back-end register port completes a req/ack transfer, returns read data.
module isa_io_responder
   import sm2201_isa_pkg::*;
#(
   parameter logic [9:0]  BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned WINDOW_BITS = WINDOW_BITS_DEF,
   parameter int unsigned MAX_WAIT    = 16
) (
   input  logic isa_clk,
   input  logic isa_reset_n,
   isa_io_responder_if.slave bus
);

   localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

   logic w_rd_act, w_wr_act, w_rd_edge, w_wr_edge;
   logic w_edge, w_both, w_hit;

   isa_state_e             r_state, w_state_nxt;
   logic                   r_chrdy, w_chrdy_nxt;
   logic                   r_is_rd, w_is_rd_nxt;
   logic                   r_reg_rd, w_reg_rd_nxt;
   logic                   r_reg_wr, w_reg_wr_nxt;
   logic                   r_err, w_err_nxt;
   logic [7:0]             r_cnt, w_cnt_nxt;
   logic [7:0]             r_dout, w_dout_nxt;
   logic [WINDOW_BITS-1:0] r_reg_addr, w_reg_addr_nxt;
   logic [7:0]             r_wdata, w_wdata_nxt;

   isa_strobe_sync u_sync (
      .i_clk     (isa_clk),
      .i_rst_n   (isa_reset_n),
      .i_ior_n   (bus.isa_ior),
      .i_iow_n   (bus.isa_iow),
      .o_rd_act  (w_rd_act),
      .o_wr_act  (w_wr_act),
      .o_rd_edge (w_rd_edge),
      .o_wr_edge (w_wr_edge)
   );

   assign w_edge = w_rd_edge | w_wr_edge;
   assign w_both = w_rd_act & w_wr_act;
   assign w_hit  = addr_hit(bus.isa_addr, BASE_ADDR, WINDOW_BITS)
                   && !bus.isa_aen && !bus.isa_ale;

   always_comb begin
      w_state_nxt    = r_state;
      w_chrdy_nxt    = r_chrdy;
      w_is_rd_nxt    = r_is_rd;
      w_reg_rd_nxt   = 1'b0;
      w_reg_wr_nxt   = 1'b0;
      w_err_nxt      = 1'b0;
      w_cnt_nxt      = r_cnt;
      w_dout_nxt     = r_dout;
      w_reg_addr_nxt = r_reg_addr;
      w_wdata_nxt    = r_wdata;

      case (r_state)
         ST_IDLE: begin
            if (w_edge) begin
               if (w_both) begin
                  w_err_nxt   = 1'b1;
                  w_is_rd_nxt = 1'b0;
                  w_state_nxt = ST_HOLD;
               end else if (w_hit) begin
                  w_chrdy_nxt    = 1'b0;
                  w_is_rd_nxt    = w_rd_act;
                  w_reg_rd_nxt   = w_rd_act;
                  w_reg_wr_nxt   = w_wr_act;
                  w_reg_addr_nxt = bus.isa_addr[WINDOW_BITS-1:0];
                  if (w_wr_act) w_wdata_nxt = bus.isa_data_in;
                  w_state_nxt    = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // Ack is tested first so an ack coinciding with the timeout wins.
            if (bus.reg_ack) begin
               if (r_is_rd) w_dout_nxt = bus.reg_rd_data;
               w_chrdy_nxt = 1'b1;
               w_state_nxt = ST_HOLD;
            end else if (r_cnt == CNT_LAST) begin
               if (r_is_rd) w_dout_nxt = TIMEOUT_RD_DATA;
               w_chrdy_nxt = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_HOLD;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_HOLD: begin
            if (!w_rd_act && !w_wr_act) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge isa_clk or negedge isa_reset_n) begin
      if (!isa_reset_n) begin
         r_state    <= ST_IDLE;
         r_chrdy    <= 1'b1;
         r_is_rd    <= 1'b0;
         r_reg_rd   <= 1'b0;
         r_reg_wr   <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_dout     <= '0;
         r_reg_addr <= '0;
         r_wdata    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_chrdy    <= w_chrdy_nxt;
         r_is_rd    <= w_is_rd_nxt;
         r_reg_rd   <= w_reg_rd_nxt;
         r_reg_wr   <= w_reg_wr_nxt;
         r_err      <= w_err_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dout     <= w_dout_nxt;
         r_reg_addr <= w_reg_addr_nxt;
         r_wdata    <= w_wdata_nxt;
      end
   end

   // The driver enable follows the synced strobe directly so it drops as soon
   // as the release is seen, without waiting for the return to IDLE.
   assign bus.isa_data_oe  = (r_state == ST_HOLD) && r_is_rd && w_rd_act;
   assign bus.isa_data_out = r_dout;
   assign bus.isa_chrdy    = r_chrdy;
   assign bus.reg_addr     = r_reg_addr;
   assign bus.reg_wr_data  = r_wdata;
   assign bus.reg_wr       = r_reg_wr;
   assign bus.reg_rd       = r_reg_rd;
   assign bus.cycle_error  = r_err;

endmodule
